// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operation encoder: ALUFun codes,
// MIPS opcode/funct values, the buffered entry struct and the buffer states.
package alu_pkg;

  // ALU function codes
  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_NEQ = 6'b110001;
  localparam logic [5:0] FUN_LT  = 6'b110101;
  localparam logic [5:0] FUN_LEZ = 6'b111101;
  localparam logic [5:0] FUN_LTZ = 6'b111011;
  localparam logic [5:0] FUN_GTZ = 6'b111111;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // One decoded operation as held in the output buffer
  typedef struct packed {
    logic [5:0]  alu_fun;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;
  } alu_entry_t;

  // Output buffer occupancy; encoding equals the entry count
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'b0, v};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational MIPS opcode/funct decode into an ALU entry.
// Branch compares are decoded only when ALU_ENC_BRANCH_EN is defined;
// otherwise those opcodes fall through to the illegal entry.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter logic [5:0] ILLEGAL_FUN = 6'b000000
) (
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output alu_entry_t  ent
);

  // Start from the illegal entry; every recognised encoding overrides it
  always_comb begin
    ent.alu_fun = ILLEGAL_FUN;
    ent.sign    = 1'b0;
    ent.a       = rs_val;
    ent.b       = rt_val;
    ent.illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ent.illegal = 1'b0;
        case (funct)
          F_ADD:  begin ent.alu_fun = FUN_ADD; ent.sign = 1'b1; end
          F_ADDU: ent.alu_fun = FUN_ADD;
          F_SUB:  begin ent.alu_fun = FUN_SUB; ent.sign = 1'b1; end
          F_SUBU: ent.alu_fun = FUN_SUB;
          F_AND:  ent.alu_fun = FUN_AND;
          F_OR:   ent.alu_fun = FUN_OR;
          F_XOR:  ent.alu_fun = FUN_XOR;
          F_NOR:  ent.alu_fun = FUN_NOR;
          F_SLT:  begin ent.alu_fun = FUN_LT; ent.sign = 1'b1; end
          F_SLTU: ent.alu_fun = FUN_LT;
          F_SLL:  begin ent.alu_fun = FUN_SLL; ent.a = {27'b0, shamt}; end
          F_SRL:  begin ent.alu_fun = FUN_SRL; ent.a = {27'b0, shamt}; end
          F_SRA:  begin ent.alu_fun = FUN_SRA; ent.a = {27'b0, shamt}; end
          default: ent.illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin ent.illegal = 1'b0; ent.alu_fun = FUN_ADD; ent.sign = 1'b1; ent.b = sext16(imm16); end
      OP_ADDIU: begin ent.illegal = 1'b0; ent.alu_fun = FUN_ADD; ent.b = sext16(imm16); end
      OP_SLTI:  begin ent.illegal = 1'b0; ent.alu_fun = FUN_LT; ent.sign = 1'b1; ent.b = sext16(imm16); end
      OP_SLTIU: begin ent.illegal = 1'b0; ent.alu_fun = FUN_LT; ent.b = sext16(imm16); end
      OP_ANDI:  begin ent.illegal = 1'b0; ent.alu_fun = FUN_AND; ent.b = zext16(imm16); end
      OP_ORI:   begin ent.illegal = 1'b0; ent.alu_fun = FUN_OR;  ent.b = zext16(imm16); end
      OP_XORI:  begin ent.illegal = 1'b0; ent.alu_fun = FUN_XOR; ent.b = zext16(imm16); end
      // lui is a left shift of the immediate by 16
      OP_LUI:   begin ent.illegal = 1'b0; ent.alu_fun = FUN_SLL; ent.a = 32'd16; ent.b = zext16(imm16); end
      // Loads/stores only need the address add
      OP_LW, OP_SW: begin ent.illegal = 1'b0; ent.alu_fun = FUN_ADD; ent.sign = 1'b1; ent.b = sext16(imm16); end
`ifdef ALU_ENC_BRANCH_EN
      OP_BEQ:    begin ent.illegal = 1'b0; ent.alu_fun = FUN_EQ;  ent.sign = 1'b1; end
      OP_BNE:    begin ent.illegal = 1'b0; ent.alu_fun = FUN_NEQ; ent.sign = 1'b1; end
      // Compares against zero carry no second operand
      OP_BLEZ:   begin ent.illegal = 1'b0; ent.alu_fun = FUN_LEZ; ent.sign = 1'b1; ent.b = 32'd0; end
      OP_BGTZ:   begin ent.illegal = 1'b0; ent.alu_fun = FUN_GTZ; ent.sign = 1'b1; ent.b = 32'd0; end
      OP_REGIMM: begin ent.illegal = 1'b0; ent.alu_fun = FUN_LTZ; ent.sign = 1'b1; ent.b = 32'd0; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_encoder.sv
// Registered ALU decode stage: valid/ready input, combinational decode,
// 2-entry skid buffer on the output so in_ready can be a flop while still
// sustaining one op per cycle. Optional branch decode: ALU_ENC_BRANCH_EN.
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int         DEPTH       = 2,
  parameter logic [5:0] ILLEGAL_FUN = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        illegal
);

  alu_entry_t dec;
  // Slot 0 is the head shown on the outputs, slot 1 the skid entry
  alu_entry_t [DEPTH-1:0] buf_q, buf_nxt;
  buf_state_t state_q, state_nxt;
  logic       in_ready_q, in_ready_nxt;
  logic       in_xfer, out_xfer;

  alu_op_decode #(.ILLEGAL_FUN(ILLEGAL_FUN)) u_dec (
    .opcode (opcode),
    .funct  (funct),
    .shamt  (shamt),
    .imm16  (imm16),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .ent    (dec)
  );

  assign out_valid = (state_q != BUF_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  assign ALUFun  = buf_q[0].alu_fun;
  assign Sign    = buf_q[0].sign;
  assign A       = buf_q[0].a;
  assign B       = buf_q[0].b;
  assign illegal = buf_q[0].illegal;

  // Buffer state, contents and registered in_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      buf_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      buf_q      <= buf_nxt;
      in_ready_q <= in_ready_nxt;
    end
  end

  // Next occupancy and entry movement for each handshake combination
  always_comb begin
    state_nxt = state_q;
    buf_nxt   = buf_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_xfer) begin
          buf_nxt[0] = dec;
          state_nxt  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) begin
          buf_nxt[0] = dec;
        end else if (in_xfer) begin
          buf_nxt[1] = dec;
          state_nxt  = BUF_FULL;
        end else if (out_xfer) begin
          state_nxt  = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // in_ready is low here, so only the output side can move
        if (out_xfer) begin
          buf_nxt[0] = buf_q[1];
          state_nxt  = BUF_ONE;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
    in_ready_nxt = (state_nxt != BUF_FULL);
  end

endmodule
